// File: rtl/tdm_demux4_if.sv
// Serial TDM sample stream in, four demultiplexed channels plus alignment status out.
// master: drives samples and observes channels; slave: the demux.
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_sync;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic [3:0]       out_valid;
  logic             frame_valid;
  logic [1:0]       slot;
  logic             locked;
  logic             sync_err;

  modport master (
    output in_valid, in_data, in_sync,
    input  out_a, out_b, out_c, out_d, out_valid, frame_valid, slot, locked, sync_err
  );

  modport slave (
    input  in_valid, in_data, in_sync,
    output out_a, out_b, out_c, out_d, out_valid, frame_valid, slot, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// 4-channel TDM demux with frame-sync alignment; 1-cycle registered outputs, no backpressure (one sample/cycle).
// Define TDM_DEMUX_SYNC_CHECK_EN to check in_sync on every locked sample (realign / drop-to-hunt on sync errors).
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  tdm_demux4_if.slave  bus
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] out_q [4];
  logic [3:0]       out_valid_q;
  logic             frame_valid_q;
  logic             sync_err_q;
  logic [1:0]       slot_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= HUNT;
      out_q[0]      <= '0;
      out_q[1]      <= '0;
      out_q[2]      <= '0;
      out_q[3]      <= '0;
      out_valid_q   <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      slot_q        <= 2'd0;
    end else begin
      out_valid_q   <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (bus.in_valid) begin
        case (state_q)
          HUNT: begin
            if (bus.in_sync) begin
              out_q[0]    <= bus.in_data;
              out_valid_q <= 4'b0001;
              slot_q      <= 2'd1;
              state_q     <= LOCKED;
            end
          end
          LOCKED: begin
`ifdef TDM_DEMUX_SYNC_CHECK_EN
            if (bus.in_sync && slot_q != 2'd0) begin
              // Early sync: restart the frame on this sample, abandoning the partial one.
              sync_err_q  <= 1'b1;
              out_q[0]    <= bus.in_data;
              out_valid_q <= 4'b0001;
              slot_q      <= 2'd1;
            end else if (!bus.in_sync && slot_q == 2'd0) begin
              sync_err_q  <= 1'b1;
              slot_q      <= 2'd0;
              state_q     <= HUNT;
            end else begin
              out_q[slot_q] <= bus.in_data;
              out_valid_q   <= 4'b0001 << slot_q;
              frame_valid_q <= (slot_q == 2'd3);
              slot_q        <= slot_q + 2'd1;
            end
`else
            // Sync ignored once locked; the slot counter free-runs.
            out_q[slot_q] <= bus.in_data;
            out_valid_q   <= 4'b0001 << slot_q;
            frame_valid_q <= (slot_q == 2'd3);
            slot_q        <= slot_q + 2'd1;
`endif
          end
          default: state_q <= HUNT;
        endcase
      end
    end
  end

  assign bus.out_a       = out_q[0];
  assign bus.out_b       = out_q[1];
  assign bus.out_c       = out_q[2];
  assign bus.out_d       = out_q[3];
  assign bus.out_valid   = out_valid_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.slot        = slot_q;
  assign bus.locked      = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4; expected values are hand-computed per step.
module tb_tdm_demux4;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tdm_demux4_if #(.WIDTH(8)) bus ();

  tdm_demux4 #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of input at the falling edge; return just after the rising edge that samples it.
  task automatic step(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sync  = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_strobes(input string tag, input logic [3:0] ov, input logic fv,
                                input logic se, input logic [1:0] sl, input logic lk);
    check({tag, ".out_valid"},   bus.out_valid, ov);
    check({tag, ".frame_valid"}, bus.frame_valid, fv);
    check({tag, ".sync_err"},    bus.sync_err, se);
    check({tag, ".slot"},        bus.slot, sl);
    check({tag, ".locked"},      bus.locked, lk);
  endtask

  task automatic expect_zero(input string tag);
    check({tag, ".out_a"}, bus.out_a, 8'h00);
    check({tag, ".out_b"}, bus.out_b, 8'h00);
    check({tag, ".out_c"}, bus.out_c, 8'h00);
    check({tag, ".out_d"}, bus.out_d, 8'h00);
    expect_strobes(tag, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus.in_valid = 1'b0;
    bus.in_sync  = 1'b0;
    bus.in_data  = 8'h00;

    // Reset
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    expect_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Acquire
    step(1'b1, 1'b0, 8'h11);
    expect_strobes("drop11", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    check("drop11.out_a", bus.out_a, 8'h00);
    step(1'b1, 1'b1, 8'hA0);
    expect_strobes("acqA0", 4'b0001, 1'b0, 1'b0, 2'd1, 1'b1);
    check("acqA0.out_a", bus.out_a, 8'hA0);
    step(1'b1, 1'b0, 8'hB1);
    expect_strobes("acqB1", 4'b0010, 1'b0, 1'b0, 2'd2, 1'b1);
    check("acqB1.out_b", bus.out_b, 8'hB1);
    step(1'b1, 1'b0, 8'hC2);
    expect_strobes("acqC2", 4'b0100, 1'b0, 1'b0, 2'd3, 1'b1);
    check("acqC2.out_c", bus.out_c, 8'hC2);
    step(1'b1, 1'b0, 8'hD3);
    expect_strobes("acqD3", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
    check("acqD3.out_d", bus.out_d, 8'hD3);
    check("acqD3.out_a", bus.out_a, 8'hA0);

    // Gapped frame
    step(1'b0, 1'b0, 8'hFF);
    expect_strobes("gap0", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 8'hE0);
    expect_strobes("gapE0", 4'b0001, 1'b0, 1'b0, 2'd1, 1'b1);
    check("gapE0.out_a", bus.out_a, 8'hE0);
    step(1'b0, 1'b1, 8'hEE);
    expect_strobes("gap1", 4'b0000, 1'b0, 1'b0, 2'd1, 1'b1);
    check("gap1.out_a", bus.out_a, 8'hE0);
    step(1'b1, 1'b0, 8'hE1);
    expect_strobes("gapE1", 4'b0010, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    expect_strobes("gap2", 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b0, 8'hE2);
    expect_strobes("gapE2", 4'b0100, 1'b0, 1'b0, 2'd3, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'hE3);
    expect_strobes("gapE3", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
    check("gapE3.out_b", bus.out_b, 8'hE1);
    check("gapE3.out_c", bus.out_c, 8'hE2);
    check("gapE3.out_d", bus.out_d, 8'hE3);

`ifdef TDM_DEMUX_SYNC_CHECK_EN
    // Early sync realigns
    step(1'b1, 1'b1, 8'hA0);
    expect_strobes("esA0", 4'b0001, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b0, 8'hB1);
    step(1'b1, 1'b1, 8'h55);
    expect_strobes("es55", 4'b0001, 1'b0, 1'b1, 2'd1, 1'b1);
    check("es55.out_a", bus.out_a, 8'h55);
    step(1'b1, 1'b0, 8'h56);
    expect_strobes("es56", 4'b0010, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b0, 8'h57);
    step(1'b1, 1'b0, 8'h58);
    expect_strobes("es58", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
    // Missing sync drops to hunt
    step(1'b1, 1'b0, 8'h77);
    expect_strobes("ms77", 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0);
    check("ms77.out_a", bus.out_a, 8'h55);
    step(1'b0, 1'b0, 8'h00);
    expect_strobes("msidle", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    // Back-to-back syncs
    step(1'b1, 1'b1, 8'h61);
    expect_strobes("bb61", 4'b0001, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b1, 8'h62);
    expect_strobes("bb62", 4'b0001, 1'b0, 1'b1, 2'd1, 1'b1);
    check("bb62.out_a", bus.out_a, 8'h62);
`else
    // Free-run: sync ignored once locked
    step(1'b1, 1'b1, 8'h90);
    step(1'b1, 1'b0, 8'h91);
    step(1'b1, 1'b0, 8'h92);
    step(1'b1, 1'b0, 8'h93);
    expect_strobes("fr93", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 8'h77);
    expect_strobes("fr77", 4'b0001, 1'b0, 1'b0, 2'd1, 1'b1);
    check("fr77.out_a", bus.out_a, 8'h77);
    step(1'b1, 1'b1, 8'h88);
    expect_strobes("fr88", 4'b0010, 1'b0, 1'b0, 2'd2, 1'b1);
    check("fr88.out_b", bus.out_b, 8'h88);
    step(1'b1, 1'b0, 8'h89);
    step(1'b1, 1'b0, 8'h8A);
    expect_strobes("fr8A", 4'b1000, 1'b1, 1'b0, 2'd0, 1'b1);
    check("fr8A.out_d", bus.out_d, 8'h8A);
`endif

    // Reset mid-frame
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hB1);
    check("mfB1.out_b", bus.out_b, 8'hB1);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sync  = 1'b0;
    bus.in_data  = 8'hC2;
    @(posedge clk);
    #1;
    expect_zero("mfrst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 1'b0, 8'hC2);
    expect_zero("mfC2");
    step(1'b1, 1'b0, 8'hD3);
    expect_zero("mfD3");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    rst = 1'b1;
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 channel mux. It takes a serial sample stream in which four channels share one data path in fixed slot order a, b, c, d, marked by a frame-sync flag on slot a. It acquires frame alignment, tracks the slot with a 2-bit counter, and steers each sample into a registered per-channel output with a one-cycle valid strobe. It sits between the serial link and the four channel consumers.

## Interface
- WIDTH, 8, sample width in bits
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  sample present on in_data this cycle
- in_data  input  WIDTH  sample data
- in_sync  input  1  marks current sample as slot a (frame start); ignored when in_valid=0
- out_a, out_b, out_c, out_d  output  WIDTH  each holds the last sample demuxed to its channel
- out_valid  output  4  one-cycle strobe per channel; bit0=a … bit3=d
- frame_valid  output  1  one-cycle strobe: complete aligned frame a..d just finished
- slot  output  2  slot expected for the next accepted sample
- locked  output  1  1 in LOCKED state
- sync_err  output  1  one-cycle alignment-error strobe

## Operation
- States: HUNT (reset state) and LOCKED.
- HUNT:
  - in_valid=1, in_sync=0: sample dropped.
  - in_valid=1, in_sync=1: sample written to out_a; out_valid[0] strobes; slot←1; enter LOCKED.
- LOCKED:
  - Each in_valid=1 sample is written to channel slot; that out_valid bit strobes; slot←slot+1, wrapping 3→0.
  - A sample written to slot 3 completes the frame if slots 0..2 of that frame were all written without an intervening error; frame_valid then strobes with out_valid[3].
  - in_valid=0: no change.
- Realign: in LOCKED with in_valid=1, in_sync=1 and slot≠0:
  - sync_err strobes.
  - Sample is treated as slot a: out_a is written, out_valid[0] strobes, slot←1.
  - The partial frame is abandoned; no frame_valid for it.
- Missing sync (SYNC_CHECK_EN only): in LOCKED with in_valid=1, in_sync=0 and slot=0:
  - sync_err strobes.
  - Sample is dropped; no out_valid.
  - State←HUNT, slot←0.
- out_a..out_d hold their value until overwritten; they are never cleared except by rst.
- At most one out_valid bit is high in any cycle.

## Timing
- Registered outputs, latency 1: a sample accepted at edge k appears on out_x with out_valid[x]=1 during the cycle after edge k.
- frame_valid, sync_err, slot and locked are all registered with the same 1-cycle latency.
- Sustains one sample per cycle. There is no backpressure; every cycle with in_valid=1 is consumed.
- Reset: on any edge with rst=1, all outputs are forced to 0 (out_a..out_d=0, out_valid=0, frame_valid=0, slot=0, locked=0, sync_err=0) and state←HUNT. This takes priority over a sample in the same cycle. Reset mid-frame discards the partial frame.
- Back-to-back sync samples (in_sync on consecutive valid samples): each one after the first is a realign with a sync_err strobe.

## Configuration
- Macro: TDM_DEMUX_SYNC_CHECK_EN.
- Defined:
  - in_sync is checked on every LOCKED sample.
  - Realign and missing-sync rules apply as above.
- Undefined:
  - in_sync is used only in HUNT to acquire lock; in LOCKED it is ignored and the slot counter free-runs.
  - LOCKED is left only by rst.
  - sync_err is tied to 0.
  - frame_valid strobes on every slot-3 write.

## Test plan
- Acquire: rst 2 cycles; in_valid samples 0x11 (no sync), then 0xA0(sync), 0xB1, 0xC2, 0xD3 -> 0x11 dropped; out_a..d = A0/B1/C2/D3; out_valid = 0001, 0010, 0100, 1000 on successive cycles; frame_valid with the last; locked=1 from the cycle after A0.
- Gapped input: same frame with in_valid=0 cycles between samples -> identical outputs, strobes delayed to match the gaps, slot holds during gaps.
- Early sync (check on): A0(sync), B1, 0x55(sync) -> sync_err=1 with out_valid=0001 and out_a=0x55; slot=1; no frame_valid.
- Missing sync (check on): full frame, then 0x77 without sync -> sync_err=1, locked=0, out_valid=0000, out_a unchanged.
- Free-run (check off): same stimulus as the missing-sync case -> 0x77 lands in out_a, sync_err stays 0, locked stays 1.
- Reset mid-frame: A0(sync), B1, rst, then C2 -> all outputs 0 after rst; C2 dropped (HUNT); no frame_valid.
